// File: rtl/snn_inference_ctrl.sv
// Sequencer for one SNN inference: walks active input spikes, issues synapse row reads,
// samples neuron spikes per timestep and reports the argmax class. Optional: SNN_CTRL_TIMEOUT_EN.
module snn_inference_ctrl #(
    parameter int unsigned N_IN        = 32,
    parameter int unsigned N_OUT       = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64,
    localparam int unsigned ADDR_W     = $clog2(N_IN),
    localparam int unsigned CLS_W      = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_spikes,
    input  logic              in_last,
    output logic              syn_req,
    output logic [ADDR_W-1:0] syn_addr,
    input  logic              syn_ack,
    input  logic [N_OUT-1:0]  neuron_spike,
    output logic              picture_done,
    output logic              result_valid,
    output logic [CLS_W-1:0]  result_class,
    output logic [CNT_W-1:0]  result_count,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WAIT_ACK,
        SETTLE,
        SAMPLE,
        DECIDE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_OUT - 1);

    state_t            state;
    logic [N_IN-1:0]   pend;
    logic              last_r;
    logic [CNT_W-1:0]  cnt [N_OUT];
    logic [CLS_W-1:0]  dec_idx;
    logic [CLS_W-1:0]  best_idx;
    logic [CNT_W-1:0]  best_cnt;
    logic [ADDR_W-1:0] low_idx;
    logic              take;
    logic              timeout_hit;

    if (TIMEOUT_CYC < 1 || N_IN < 2 || N_OUT < 2 || CNT_W < 1) begin : g_bad_params
        $error("snn_inference_ctrl: invalid parameter set");
    end

    // Lowest pending input index; scanning downward lets the lowest set bit win.
    always_comb begin
        low_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                low_idx = ADDR_W'(i);
            end
        end
    end

    // Strict compare keeps the earliest index on ties.
    assign take = cnt[dec_idx] > best_cnt;

`ifdef SNN_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] wait_cnt;
    logic            err_r;

    assign timeout_hit = !syn_ack && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign err_timeout = err_r;

    // Cycles spent waiting on the current row; restarts on every WAIT_ACK entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_r    <= 1'b0;
        end else begin
            if (state != WAIT_ACK) begin
                wait_cnt <= '0;
            end else if (!syn_ack) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
            if (state == WAIT_ACK && timeout_hit) begin
                err_r <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            syn_req      <= 1'b0;
            syn_addr     <= '0;
            picture_done <= 1'b0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_count <= '0;
            pend         <= '0;
            last_r       <= 1'b0;
            dec_idx      <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                cnt[j] <= '0;
            end
        end else begin
            picture_done <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pend     <= in_spikes;
                        last_r   <= in_last;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (pend != '0) begin
                        syn_addr <= low_idx;
                        syn_req  <= 1'b1;
                        state    <= WAIT_ACK;
                    end else begin
                        state <= SETTLE;
                    end
                end
                WAIT_ACK: begin
                    // A timed-out row is dropped exactly like an acknowledged one.
                    if (syn_ack || timeout_hit) begin
                        pend[syn_addr] <= 1'b0;
                        syn_req        <= 1'b0;
                        state          <= SCAN;
                    end
                end
                SETTLE: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        if (neuron_spike[j] && cnt[j] != CNT_MAX) begin
                            cnt[j] <= cnt[j] + CNT_W'(1);
                        end
                    end
                    dec_idx  <= '0;
                    best_idx <= '0;
                    best_cnt <= '0;
                    if (last_r) begin
                        state <= DECIDE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DECIDE: begin
                    if (take) begin
                        best_cnt <= cnt[dec_idx];
                        best_idx <= dec_idx;
                    end
                    if (dec_idx == LAST_IDX) begin
                        result_class <= take ? dec_idx : best_idx;
                        result_count <= take ? cnt[dec_idx] : best_cnt;
                        result_valid <= 1'b1;
                        picture_done <= 1'b1;
                        state        <= DONE;
                    end else begin
                        dec_idx <= dec_idx + CLS_W'(1);
                    end
                end
                DONE: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        cnt[j] <= '0;
                    end
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    syn_req  <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Directed bench for snn_inference_ctrl: row-address and result scoreboards fed by the stimulus.
module tb_snn_inference_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_spikes;
    logic        in_last;
    logic        syn_req;
    logic [4:0]  syn_addr;
    logic        syn_ack;
    logic [15:0] neuron_spike;
    logic        picture_done;
    logic        result_valid;
    logic [3:0]  result_class;
    logic [7:0]  result_count;
    logic        err_timeout;

    snn_inference_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_spikes    (in_spikes),
        .in_last      (in_last),
        .syn_req      (syn_req),
        .syn_addr     (syn_addr),
        .syn_ack      (syn_ack),
        .neuron_spike (neuron_spike),
        .picture_done (picture_done),
        .result_valid (result_valid),
        .result_class (result_class),
        .result_count (result_count),
        .err_timeout  (err_timeout)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    int unsigned accept_cyc = 0;
    logic        chk_lat = 1'b0;
    logic        ack_en = 1'b1;
    int          ack_dly = 0;
    int          ack_cnt = 0;
    int          res_pulses = 0;
    int          late_req = 0;
    int          late_done = 0;
    logic        skip_en = 1'b0;
    logic [4:0]  skip_addr = 5'd0;

    logic [4:0]  exp_addr [$];
    logic [11:0] exp_res [$];
    int unsigned m_cnt [16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < 16; j++) m_cnt[j] = 0;
    endtask

    // Send one timestep; the row-address and result expectations are queued here.
    task automatic send(input logic [31:0] sp, input logic last, input logic [15:0] ns);
        int t;
        int unsigned best;
        int unsigned bc;
        t = 0;
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 32; i++) if (sp[i]) exp_addr.push_back(5'(i));
        for (int j = 0; j < 16; j++) if (ns[j] && m_cnt[j] < 255) m_cnt[j]++;
        if (last) begin
            best = 0;
            bc = m_cnt[0];
            for (int j = 1; j < 16; j++) begin
                if (m_cnt[j] > bc) begin
                    bc = m_cnt[j];
                    best = j;
                end
            end
            exp_res.push_back({4'(best), 8'(bc)});
            model_clear();
        end
        neuron_spike = ns;
        in_spikes = sp;
        in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        accept_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_res.size() != 0 || !in_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_results", 32'(exp_res.size()), 32'd0);
    endtask

    // Synapse-matrix responder: checks each requested row and answers with an ack.
    initial begin
        int n;
        syn_ack = 1'b0;
        forever begin
            @(negedge clk);
            syn_ack = 1'b0;
            if (late_req != late_done) begin
                syn_ack = 1'b1;
                late_done = late_req;
            end else if (syn_req && ack_en) begin
                if (exp_addr.size() == 0) check("unexpected_req", {27'd0, syn_addr}, 32'hFFFF);
                else check("syn_addr", {27'd0, syn_addr}, {27'd0, exp_addr.pop_front()});
                if (skip_en && syn_addr == skip_addr) begin
                    n = 1;
                    while (syn_req && n < 200) begin
                        @(negedge clk);
                        if (syn_req) n++;
                    end
                    check("timeout_req_cycles", 32'(n), 32'd64);
                    check("err_timeout_set", {31'd0, err_timeout}, 32'd1);
                    skip_en = 1'b0;
                end else begin
                    repeat (ack_dly) @(negedge clk);
                    syn_ack = 1'b1;
                    ack_cnt++;
                end
            end
        end
    end

    // Result monitor: pops the scoreboard on every result pulse.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                res_pulses++;
                check("picture_done_with_result", {31'd0, picture_done}, 32'd1);
                if (chk_lat) check("result_latency", cyc - accept_cyc, 32'd19);
                if (exp_res.size() == 0) begin
                    check("unexpected_result", 32'd0, 32'd1);
                end else begin
                    e = exp_res.pop_front();
                    check("result_class", {28'd0, result_class}, {28'd0, e[11:8]});
                    check("result_count", {24'd0, result_count}, {24'd0, e[7:0]});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1;
        in_valid = 1'b0;
        in_spikes = '0;
        in_last = 1'b0;
        neuron_spike = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_syn_req", {31'd0, syn_req}, 32'd0);
        check("rst_syn_addr", {27'd0, syn_addr}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_picture_done", {31'd0, picture_done}, 32'd0);
        check("rst_result_class", {28'd0, result_class}, 32'd0);
        check("rst_result_count", {24'd0, result_count}, 32'd0);
        check("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset while a row read is outstanding, then a stray ack.
        ack_en = 1'b0;
        send(32'h0000_0020, 1'b0, 16'h0000);
        t = 0;
        while (!syn_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("t1_req_raised", {31'd0, syn_req}, 32'd1);
        check("t1_req_addr", {27'd0, syn_addr}, 32'd5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t1_req_dropped", {31'd0, syn_req}, 32'd0);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        check("t1_err_timeout", {31'd0, err_timeout}, 32'd0);
        rst = 1'b0;
        exp_addr.delete();
        exp_res.delete();
        model_clear();
        late_req++;
        repeat (4) @(negedge clk);
        check("t1_late_ack_no_req", {31'd0, syn_req}, 32'd0);
        check("t1_late_ack_in_ready", {31'd0, in_ready}, 32'd1);
        ack_en = 1'b1;

        // Rows 0, 2, 15 read in order, one ack each, a single result pulse.
        ack_cnt = 0;
        res_pulses = 0;
        send(32'h0000_8005, 1'b1, 16'h0100);
        wait_done();
        check("t2_ack_count", 32'(ack_cnt), 32'd3);
        check("t2_addr_queue_empty", 32'(exp_addr.size()), 32'd0);
        check("t2_result_pulses", 32'(res_pulses), 32'd1);

        // Three timesteps with neuron 4 firing, slower acks.
        ack_dly = 2;
        send(32'h0000_0001, 1'b0, 16'h0010);
        send(32'h0000_0006, 1'b0, 16'h0010);
        send(32'h0000_0000, 1'b1, 16'h0010);
        wait_done();
        check("t3_class", {28'd0, result_class}, 32'd4);
        check("t3_count", {24'd0, result_count}, 32'd3);
        ack_dly = 0;

        // Tie between neurons 0 and 1 over 300 timesteps saturates at 255.
        for (int i = 0; i < 300; i++) begin
            send(32'h0000_0000, 1'(i == 299), 16'h0003);
        end
        wait_done();
        check("t4_class", {28'd0, result_class}, 32'd0);
        check("t4_count", {24'd0, result_count}, 32'd255);

        // Empty picture: no row reads, result after 3 + N_OUT cycles.
        ack_cnt = 0;
        chk_lat = 1'b1;
        send(32'h0000_0000, 1'b1, 16'h0000);
        wait_done();
        chk_lat = 1'b0;
        check("t5_no_acks", 32'(ack_cnt), 32'd0);
        check("t5_count", {24'd0, result_count}, 32'd0);

`ifdef SNN_CTRL_TIMEOUT_EN
        // Row 3 never answers; row 4 is requested next and the picture completes.
        skip_en = 1'b1;
        skip_addr = 5'd3;
        send(32'h0000_0018, 1'b1, 16'h0004);
        wait_done();
        check("t6_err_sticky", {31'd0, err_timeout}, 32'd1);
        check("t6_class", {28'd0, result_class}, 32'd2);
`else
        check("err_timeout_tied", {31'd0, err_timeout}, 32'd0);
`endif

        check("final_addr_queue_empty", 32'(exp_addr.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
